// File: rtl/sa_pkg.sv
// Shared constants, state type and arithmetic helpers for the accumulator bank.
// SA_ACCU_RELU_EN selects ReLU clipping in the quantiser.
package sa_pkg;

  localparam int NUM_COL = 16;
  localparam int DATA_W  = 8;
  localparam int ACC_W   = 20;
  localparam int DEPTH   = 784;
  localparam int OUT_W   = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    DONE
  } accu_state_t;

  function automatic logic signed [ACC_W-1:0] sat_add(
    input logic signed [ACC_W-1:0]  a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [ACC_W:0] s;
    s = {a[ACC_W-1], a}
      + {{(ACC_W+1-DATA_W){b[DATA_W-1]}}, b};
    if (s[ACC_W] != s[ACC_W-1])
      sat_add = s[ACC_W]
        ? {1'b1, {(ACC_W-1){1'b0}}}
        : {1'b0, {(ACC_W-1){1'b1}}};
    else
      sat_add = s[ACC_W-1:0];
  endfunction

  function automatic logic [OUT_W-1:0] quant(
    input logic signed [ACC_W-1:0] a,
    input int unsigned             sh
  );
    logic signed [ACC_W-1:0] v;
    logic signed [ACC_W-1:0] lo;
    logic signed [ACC_W-1:0] hi;
    v  = a >>> sh;
    hi = ACC_W'(127);
`ifdef SA_ACCU_RELU_EN
    lo = ACC_W'(0);
`else
    lo = ACC_W'(-128);
`endif
    if (v < lo)
      quant = lo[OUT_W-1:0];
    else if (v > hi)
      quant = hi[OUT_W-1:0];
    else
      quant = v[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/sa_accu_col.sv
// One accumulator column: beat counters, RMW pipeline with
// write-to-read forwarding, column buffer and drain read port.
module sa_accu_col #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int DEPTH  = 784,
  parameter int ADDR_W = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic                     drain,
  input  logic [ADDR_W-1:0]        pix_max,
  input  logic [5:0]               pass_max,
  input  logic                     valid,
  input  logic signed [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic                     complete,
  output logic                     ovf,
  output logic signed [ACC_W-1:0]  rd_data
);
  import sa_pkg::*;

  logic [ADDR_W-1:0] pix;
  logic [5:0]        pass;
  logic              take;

  logic                     s1_vld;
  logic                     s1_first;
  logic [ADDR_W-1:0]        s1_addr;
  logic signed [DATA_W-1:0] s1_data;
  logic                     fwd;
  logic signed [ACC_W-1:0]  fwd_q;
  logic signed [ACC_W-1:0]  mem_q;
  logic signed [ACC_W-1:0]  old;
  logic signed [ACC_W-1:0]  wdata;
  logic [ADDR_W-1:0]        ra;

  logic signed [ACC_W-1:0] mem [DEPTH];

  assign take = valid && en && !complete;
  assign ovf  = valid && !(en && !complete);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix      <= '0;
      pass     <= '0;
      complete <= 1'b0;
    end else if (clr) begin
      pix      <= '0;
      pass     <= '0;
      complete <= 1'b0;
    end else if (take) begin
      if (pix == pix_max) begin
        pix <= '0;
        if (pass == pass_max)
          complete <= 1'b1;
        else
          pass <= pass + 1'b1;
      end else begin
        pix <= pix + 1'b1;
      end
    end
  end

  // A read on the same edge as a write to that entry sees the old
  // value, so the just-written sum is replayed instead.
  assign ra    = drain ? rd_addr : pix;
  assign old   = fwd ? fwd_q : mem_q;
  assign wdata = s1_first ? ACC_W'(s1_data)
                          : sat_add(old, s1_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_first <= 1'b0;
      s1_addr  <= '0;
      s1_data  <= '0;
      fwd      <= 1'b0;
      fwd_q    <= '0;
    end else begin
      s1_vld   <= take;
      s1_first <= (pass == '0);
      s1_addr  <= pix;
      s1_data  <= data;
      fwd      <= s1_vld && (s1_addr == ra);
      fwd_q    <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_vld)
      mem[s1_addr] <= wdata;
    mem_q <= mem[ra];
  end

  assign rd_data = old;

endmodule

// File: rtl/sa_accu_bank.sv
// Systolic-array output accumulator bank with quantised valid/ready drain.
// SA_ACCU_RELU_EN selects ReLU clipping of the drained lanes.
module sa_accu_bank #(
  parameter int NUM_COL   = sa_pkg::NUM_COL,
  parameter int DATA_W    = sa_pkg::DATA_W,
  parameter int ACC_W     = sa_pkg::ACC_W,
  parameter int DEPTH     = sa_pkg::DEPTH,
  parameter int OUT_SHIFT = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [4:0]               ofmap_size_i,
  input  logic [5:0]               num_pass_i,
  input  logic signed [DATA_W-1:0] accu_data_i [NUM_COL],
  input  logic                     accu_valid_i [NUM_COL],
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [7:0]               out_data_o [NUM_COL],
  output logic                     out_last_o,
  output logic                     done_o,
  output logic                     busy_o,
  output logic                     overflow_o
);
  import sa_pkg::*;

  localparam int AW = $clog2(DEPTH);

  accu_state_t state;

  logic [4:0]    side;
  logic [AW-1:0] pix_max;
  logic [5:0]    pass_max;
  logic          start_ok;
  logic          accum;
  logic          go;
  logic          drain;
  logic          all_cmp;
  logic          pop;
  logic          issue;
  logic [1:0]    occ;

  logic [NUM_COL-1:0] cmp;
  logic [NUM_COL-1:0] ovf;

  logic [AW-1:0] raddr;
  logic          rd_vld;
  logic          rd_last;
  logic          rd_done;
  logic          sk_vld;
  logic          sk_last;

  logic signed [ACC_W-1:0] rd [NUM_COL];
  logic [7:0]              rq [NUM_COL];
  logic [7:0]              sk [NUM_COL];

  always_comb begin
    side = ofmap_size_i;
    if (side == 5'd0)
      side = 5'd1;
    else if (side > 5'd28)
      side = 5'd28;
  end

  assign start_ok = start && (state == IDLE);
  assign accum    = (state == ACCUM);
  assign all_cmp  = &cmp;
  assign go       = accum && all_cmp;
  assign drain    = go || (state == DRAIN);
  assign pop      = out_valid_o && out_ready_i;

  for (genvar c = 0; c < NUM_COL; c++) begin : g_col
    sa_accu_col #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W),
      .DEPTH  (DEPTH),
      .ADDR_W (AW)
    ) u_col (
      .clk      (clk),
      .rst      (rst),
      .clr      (start_ok),
      .en       (accum),
      .drain    (drain),
      .pix_max  (pix_max),
      .pass_max (pass_max),
      .valid    (accu_valid_i[c]),
      .data     (accu_data_i[c]),
      .rd_addr  (raddr),
      .complete (cmp[c]),
      .ovf      (ovf[c]),
      .rd_data  (rd[c])
    );
    assign rq[c] = quant(rd[c], OUT_SHIFT);
  end

  // Reads are issued only when the word they return is sure to
  // find room in the output register or the skid slot.
  assign occ   = 2'(out_valid_o) + 2'(sk_vld) + 2'(rd_vld);
  assign issue = drain && !rd_done
              && ((occ - 2'(pop)) < 2'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raddr   <= '0;
      rd_vld  <= 1'b0;
      rd_last <= 1'b0;
      rd_done <= 1'b0;
    end else if (start_ok) begin
      raddr   <= '0;
      rd_vld  <= 1'b0;
      rd_last <= 1'b0;
      rd_done <= 1'b0;
    end else begin
      rd_vld  <= issue;
      rd_last <= issue && (raddr == pix_max);
      if (issue) begin
        if (raddr == pix_max)
          rd_done <= 1'b1;
        else
          raddr <= raddr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_o <= 1'b0;
      out_last_o  <= 1'b0;
      sk_vld      <= 1'b0;
      sk_last     <= 1'b0;
      for (int c = 0; c < NUM_COL; c++) begin
        out_data_o[c] <= '0;
        sk[c]         <= '0;
      end
    end else if (pop || !out_valid_o) begin
      if (sk_vld) begin
        out_valid_o <= 1'b1;
        out_data_o  <= sk;
        out_last_o  <= sk_last;
        sk_vld      <= rd_vld;
        if (rd_vld) begin
          sk      <= rq;
          sk_last <= rd_last;
        end
      end else begin
        out_valid_o <= rd_vld;
        out_last_o  <= rd_vld && rd_last;
        if (rd_vld)
          out_data_o <= rq;
      end
    end else if (rd_vld) begin
      sk_vld  <= 1'b1;
      sk      <= rq;
      sk_last <= rd_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      overflow_o <= 1'b0;
      pix_max    <= '0;
      pass_max   <= '0;
    end else begin
      done_o <= 1'b0;
      if (|ovf)
        overflow_o <= 1'b1;
      unique case (state)
        IDLE: begin
          if (start) begin
            state      <= ACCUM;
            busy_o     <= 1'b1;
            overflow_o <= 1'b0;
            pix_max    <= AW'(side) * AW'(side) - 1'b1;
            pass_max   <= (num_pass_i == 6'd0) ? 6'd0
                                               : num_pass_i - 6'd1;
          end
        end
        ACCUM: begin
          if (all_cmp)
            state <= DRAIN;
        end
        DRAIN: begin
          if (pop && out_last_o) begin
            state  <= DONE;
            done_o <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
